// File: rtl/prog_loader_if.sv
// ----------------------------------------------------------------------------
// prog_loader_if
//   Groups the two channels of the program loader:
//     - the byte stream from the host link (valid/ready, little-endian bytes,
//       in_last on the final byte of the image);
//     - the word write port shared by instruction and data memory.
//
//   Signals
//     in_valid   host -> loader   byte stream valid
//     in_data    host -> loader   byte stream data
//     in_last    host -> loader   qualifies the final byte of the image
//     in_ready   loader -> host   byte stream ready
//     mem_we     loader -> mem    one-cycle write strobe
//     mem_addr   loader -> mem    byte address of the word being written
//     mem_wdata  loader -> mem    word being written
//     mem_wstrb  loader -> mem    byte enables, bit i covers wdata[8i+7:8i]
//
//   Modports
//     master  host / memory side (drives the stream, observes the writes)
//     slave   loader side
// ----------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
//   Streams a program image into the core's instruction and data memories.
//   Bytes arrive little-endian over a valid/ready channel, are assembled into
//   32-bit words, and each word is written to IM and DM in parallel through a
//   shared write port. The core is held in reset during the load and released
//   only after a complete image that fits in DEPTH_WORDS has been written.
//   An image larger than the memory is drained and reported with err; the
//   core then stays in reset until the next start.
//
//   Parameters
//     DEPTH_WORDS  memory capacity in 32-bit words
//     START_ADDR   byte address of the first word (must be 4-byte aligned)
//     ADDR_W       width of mem_addr and word_count
//
//   Ports
//     clk         clock
//     rst         asynchronous reset, active-low
//     start       one-cycle pulse; begins (or restarts) a load
//     bus         byte stream in + memory write port (slave modport)
//     core_rst    active-high reset to the core; 1 = core held in reset
//     done        image loaded, core released
//     err         overflow detected, core stays in reset
//     word_count  number of words written in the current load (saturating)
// ----------------------------------------------------------------------------
module prog_loader #(
    parameter int DEPTH_WORDS = 16384,
    parameter int START_ADDR  = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.slave      bus,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE,
        S_DRAIN,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(START_ADDR);

    state_t            state;
    state_t            state_nxt;

    logic [1:0]        idx;        // next lane to fill in the assembly register
    logic [31:0]       asm_word;   // partially assembled word, unfilled lanes zero
    logic [ADDR_W-1:0] taken;      // words handed to the write register so far

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    logic              ready;
    logic              accept;
    logic              restart;
    logic              take;
    logic              word_end;
    logic [31:0]       word_nxt;
    logic [3:0]        strb_nxt;

    assign ready  = (state == S_LOAD) || (state == S_DRAIN);
    assign accept = bus.in_valid && ready;

    // ------------------------------------------------------------------
    // Next-state and per-cycle control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        restart   = 1'b0;
        take      = 1'b0;
        word_end  = 1'b0;
        word_nxt  = asm_word;
        word_nxt[{idx, 3'b000} +: 8] = bus.in_data;

        case (idx)
            2'd0:    strb_nxt = 4'b0001;
            2'd1:    strb_nxt = 4'b0011;
            2'd2:    strb_nxt = 4'b0111;
            default: strb_nxt = 4'b1111;
        endcase

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    restart   = 1'b1;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    // Overflow is judged on words already committed for
                    // writing (taken), not on word_count: word_count lags by
                    // the one-cycle write, and a byte right behind the last
                    // fitting word must still be caught.
                    if (idx == 2'd0 && taken == DEPTH) begin
                        state_nxt = bus.in_last ? S_ERR : S_DRAIN;
                    end else begin
                        take     = 1'b1;
                        word_end = (idx == 2'd3) || bus.in_last;
                        if (bus.in_last) state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_nxt = S_DONE;
            S_DRAIN: begin
                if (accept && bus.in_last) state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this clock edge.
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Word assembly, write register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= 2'd0;
            asm_word   <= 32'h0;
            taken      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            word_count <= '0;
        end else begin
            we_q <= 1'b0;
            if (we_q && word_count != DEPTH) word_count <= word_count + ADDR_W'(1);

            if (restart) begin
                idx        <= 2'd0;
                asm_word   <= 32'h0;
                taken      <= '0;
                word_count <= '0;
            end else if (take) begin
                if (word_end) begin
                    // Address, data and strobe only change on a write, so
                    // they hold their last values while mem_we is low.
                    we_q     <= 1'b1;
                    addr_q   <= BASE + {taken[ADDR_W-3:0], 2'b00};
                    wdata_q  <= word_nxt;
                    wstrb_q  <= strb_nxt;
                    asm_word <= 32'h0;
                    idx      <= 2'd0;
                    taken    <= taken + ADDR_W'(1);
                end else begin
                    asm_word <= word_nxt;
                    idx      <= idx + 2'd1;
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;

    assign core_rst = (state != S_DONE);
    assign done     = (state == S_DONE);
    assign err      = (state == S_DRAIN) || (state == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_prog_loader
//   Two loaders share one byte stream: dut_a with the full memory depth and
//   dut_b with a 4-word memory, so every image also exercises the overflow
//   path. Expected writes and final status come from an image-level model:
//   the image is cut into 4-byte little-endian words, the first
//   min(words, depth) are written, and an image longer than the memory
//   ends in err instead of done.
// ----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int DEPTH_A = 16384;
    localparam int DEPTH_B = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last  = 1'b0;
    logic [7:0]  in_data  = 8'h0;

    logic        core_rst_a, done_a, err_a;
    logic        core_rst_b, done_b, err_b;
    logic [31:0] wc_a, wc_b;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(32)) bus_a ();
    prog_loader_if #(.ADDR_W(32)) bus_b ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in_data  = in_data;
    assign bus_a.in_last  = in_last;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_data  = in_data;
    assign bus_b.in_last  = in_last;

    prog_loader #(.DEPTH_WORDS(DEPTH_A), .START_ADDR(0), .ADDR_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .bus(bus_a),
        .core_rst(core_rst_a), .done(done_a), .err(err_a), .word_count(wc_a)
    );

    prog_loader #(.DEPTH_WORDS(DEPTH_B), .START_ADDR(0), .ADDR_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start), .bus(bus_b),
        .core_rst(core_rst_b), .done(done_b), .err(err_b), .word_count(wc_b)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] img[$];
    wr_t        obs_q[2][$];
    wr_t        exp_q[2][$];
    int         exp_cnt[2];
    bit         exp_ovf[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus_a.mem_we === 1'b1)
            obs_q[0].push_back(wr_t'{bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_wstrb});
        if (bus_b.mem_we === 1'b1)
            obs_q[1].push_back(wr_t'{bus_b.mem_addr, bus_b.mem_wdata, bus_b.mem_wstrb});
    end

    // Image-level reference: word w covers bytes 4w..4w+3; missing bytes are
    // zero with their strobe bit clear.
    task automatic build_expect();
        int n;
        int words;
        int depth;
        int nw;
        wr_t e;
        n     = img.size();
        words = (n + 3) / 4;
        for (int d = 0; d < 2; d++) begin
            depth      = (d == 0) ? DEPTH_A : DEPTH_B;
            nw         = (words < depth) ? words : depth;
            exp_ovf[d] = (words > depth);
            exp_cnt[d] = nw;
            exp_q[d].delete();
            for (int w = 0; w < nw; w++) begin
                e.addr = 32'(4 * w);
                e.data = 32'h0;
                e.strb = 4'h0;
                for (int b = 0; b < 4; b++) begin
                    if (4 * w + b < n) begin
                        e.data[8*b +: 8] = img[4*w+b];
                        e.strb[b]        = 1'b1;
                    end
                end
                exp_q[d].push_back(e);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, bus_a.in_ready, 0);
        check({tag, "_we"},    bus_a.mem_we, 0);
        check({tag, "_addr"},  bus_a.mem_addr, 0);
        check({tag, "_wdata"}, bus_a.mem_wdata, 0);
        check({tag, "_wstrb"}, bus_a.mem_wstrb, 0);
        check({tag, "_crst"},  core_rst_a, 1);
        check({tag, "_done"},  done_a, 0);
        check({tag, "_err"},   err_a, 0);
        check({tag, "_wc"},    wc_a, 0);
        check({tag, "_err_b"}, err_b, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Offer one byte from the current negedge until accepted; returns with
    // the acceptance edge just behind us (at the following negedge).
    task automatic send_byte(input logic [7:0] b, input bit last, input bit mid_start,
                             inout int stalls);
        int tmo;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        start    = mid_start;
        tmo      = 0;
        while ((bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1) && tmo < 16) begin
            @(negedge clk);
            tmo++;
        end
        stalls += tmo;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input bit do_start, input bit gaps,
                            input bit mid_start);
        int  stalls;
        wr_t last_wr;
        build_expect();
        obs_q[0].delete();
        obs_q[1].delete();
        if (do_start) pulse_start();
        stalls = 0;
        foreach (img[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            send_byte(img[i], (i == img.size() - 1), (mid_start && i == 1), stalls);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        // One cycle after the last byte: final write in flight, not yet done.
        check({tag, "_flush_we"},   bus_a.mem_we, 1);
        check({tag, "_flush_done"}, done_a, 0);
        @(negedge clk);
        // Two cycles after the last byte: released (or failed for dut_b).
        check({tag, "_done_a"}, done_a, 1);
        check({tag, "_crst_a"}, core_rst_a, 0);
        check({tag, "_err_a"},  err_a, 0);
        check({tag, "_wc_a"},   wc_a, 32'(exp_cnt[0]));
        check({tag, "_done_b"}, done_b, !exp_ovf[1]);
        check({tag, "_crst_b"}, core_rst_b, exp_ovf[1]);
        check({tag, "_err_b"},  err_b, exp_ovf[1]);
        check({tag, "_wc_b"},   wc_b, 32'(exp_cnt[1]));
        check({tag, "_stalls"}, stalls, 0);

        last_wr = exp_q[0][exp_q[0].size()-1];
        check({tag, "_hold_addr"},  bus_a.mem_addr, last_wr.addr);
        check({tag, "_hold_wdata"}, bus_a.mem_wdata, last_wr.data);

        for (int d = 0; d < 2; d++) begin
            check({tag, (d == 0) ? "_nwr_a" : "_nwr_b"}, obs_q[d].size(), exp_q[d].size());
            for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
                check({tag, "_wr_addr"}, obs_q[d][i].addr, exp_q[d][i].addr);
                check({tag, "_wr_data"}, obs_q[d][i].data, exp_q[d][i].data);
                check({tag, "_wr_strb"}, obs_q[d][i].strb, exp_q[d][i].strb);
            end
        end
    endtask

    task automatic rand_image(input int len);
        img.delete();
        for (int i = 0; i < len; i++) img.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int dummy;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", bus_a.in_ready, 0);
        check("idle_crst", core_rst_a, 1);

        // Two full words.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
        run_load("t1", 1, 0, 0);

        // Full word then a one-byte partial word.
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load("t2", 1, 0, 0);

        // Two-word image with idle gaps and an ignored start in LOAD.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
        run_load("t3", 1, 1, 1);

        // 20 bytes: dut_b overflows after 4 words and drains.
        rand_image(20);
        run_load("t4", 1, 1, 0);

        // 17 bytes: the overflowing byte itself is the last one.
        rand_image(17);
        run_load("t4b", 1, 0, 0);

        // Reset after 6 bytes, then a clean reload.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
        pulse_start();
        dummy = 0;
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0, 1'b0, dummy);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_load("t5", 1, 0, 0);

        // Restart from DONE.
        pulse_start();
        check("t6_crst", core_rst_a, 1);
        check("t6_done", done_a, 0);
        check("t6_wc",   wc_a, 0);
        img = '{8'h37, 8'h11, 8'h22, 8'h33};
        run_load("t6", 0, 0, 0);

        // Random images, lengths around the dut_b capacity.
        for (int k = 0; k < 8; k++) begin
            rand_image($urandom_range(1, 24));
            run_load("rnd", 1, 1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
